// File: rtl/rst_ctrl_pkg.sv
// Shared types and defaults for the core reset sequencer and interrupt conditioner.
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        NDM  = 2'd2
    } rst_state_e;

    localparam int DefaultNumSources      = 2;
    localparam int DefaultSyncStages      = 2;
    localparam int DefaultResetHoldCycles = 16;
    localparam int DefaultCountWidth      = 8;

endpackage

// File: rtl/rst_irq_sync.sv
// Single-bit multi-stage synchroniser for one asynchronous interrupt line.
module rst_irq_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SyncStages-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SyncStages-2:0], d};
        end
    end

    assign q = stages[SyncStages-1];

endmodule

// File: rtl/core_rst_irq_ctrl.sv
// Core/peripheral reset sequencer with held release, plus per-line
// interrupt synchronisation and level/edge conditioning gated by RUN.
module core_rst_irq_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int                     NumSources      = DefaultNumSources,
    parameter logic [NumSources-1:0]  IrqEdgeMask     = '0,
    parameter int                     SyncStages      = DefaultSyncStages,
    parameter int                     ResetHoldCycles = DefaultResetHoldCycles,
    parameter int                     CountWidth      = DefaultCountWidth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   test_en,
    input  logic                   debug_ndreset,
    input  logic [NumSources-1:0]  irq_sources,
    output logic [NumSources-1:0]  core_irq,
    output logic                   core_rst_n,
    output logic                   ndmreset_n,
    output logic                   core_running,
    output logic [CountWidth-1:0]  ndm_count
);

    localparam int CntW = (ResetHoldCycles > 1) ? $clog2(ResetHoldCycles) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(ResetHoldCycles - 1);

    rst_state_e            state;
    rst_state_e            next_state;
    logic [CntW-1:0]       hold_cnt;
    logic                  core_rst_q;
    logic                  ndmreset_q;
    logic [NumSources-1:0] irq_sync;
    logic [NumSources-1:0] irq_prev;
    logic [NumSources-1:0] irq_cond;

    always_comb begin
        next_state = state;
        unique case (state)
            HOLD: begin
                if (debug_ndreset)          next_state = NDM;
                else if (hold_cnt == HoldLast) next_state = RUN;
            end
            RUN:     if (debug_ndreset) next_state = NDM;
            NDM:     if (!debug_ndreset) next_state = HOLD;
            default: next_state = HOLD;
        endcase
    end

    // Counter only advances while staying in HOLD, so any entry into HOLD starts a full hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            core_rst_q   <= 1'b0;
            ndmreset_q   <= 1'b0;
            core_running <= 1'b0;
            ndm_count    <= '0;
            irq_prev     <= '0;
            core_irq     <= '0;
        end else begin
            state        <= next_state;
            hold_cnt     <= (state == HOLD && next_state == HOLD) ? hold_cnt + CntW'(1) : '0;
            core_rst_q   <= (next_state == RUN);
            ndmreset_q   <= (next_state == RUN);
            core_running <= (next_state == RUN);
            if (next_state == NDM && state != NDM && ndm_count != '1) begin
                ndm_count <= ndm_count + CountWidth'(1);
            end
            irq_prev     <= irq_sync;
            core_irq     <= irq_cond & {NumSources{next_state == RUN}};
        end
    end

    for (genvar i = 0; i < NumSources; i++) begin : g_irq
        rst_irq_sync #(
            .SyncStages(SyncStages)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (irq_sources[i]),
            .q    (irq_sync[i])
        );
        assign irq_cond[i] = IrqEdgeMask[i] ? (irq_sync[i] & ~irq_prev[i]) : irq_sync[i];
    end

    // DFT bypass hands reset control straight to the board reset.
    assign core_rst_n = test_en ? rst_n : core_rst_q;
    assign ndmreset_n = test_en ? rst_n : ndmreset_q;

endmodule
